// File: rtl/noc_pkg.sv
// noc_pkg: shared packet geometry and output identifiers for the NoC demux
package noc_pkg;
    localparam int WIDTH_PACKAGE = 33;
    localparam int DEST_BIT = 32;
    localparam int OUT0 = 0;
    localparam int OUT1 = 1;
    typedef logic [WIDTH_PACKAGE-1:0] packet_t;
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: circular-buffer FIFO with occupancy count 0..DEPTH
module noc_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

    // storage is cleared too so the output data reads 0 while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
        end
    end
endmodule

// File: rtl/noc_demux_2channel.sv
// noc_demux_2channel: steers a merged packet stream to one of two FIFO-buffered
// outputs by a destination bit, with per-output delivery counters.
module noc_demux_2channel #(
    parameter int WIDTH_PACKAGE = noc_pkg::WIDTH_PACKAGE,
    parameter int DEST_BIT      = noc_pkg::DEST_BIT,
    parameter int DEPTH         = 2,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH_PACKAGE-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH_PACKAGE-1:0] out0_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [WIDTH_PACKAGE-1:0] out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [CNT_W-1:0]         cnt0,
    output logic [CNT_W-1:0]         cnt1
);
    import noc_pkg::*;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH_PACKAGE-1:0] hold_data_q, hold_data_d;
    logic                     hold_valid_q, hold_valid_d;
    logic                     rdy_q;
    logic [CNT_W-1:0]         cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                     dispatch, accept;
    logic [1:0]               push, pop, full, empty, ready, valid;
    logic [WIDTH_PACKAGE-1:0] rdata [2];
    logic [CW-1:0]            count [2];

    assign ready = {out1_ready, out0_ready};

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        assign push[k]  = dispatch & (hold_data_q[DEST_BIT] == 1'(k));
        assign pop[k]   = ready[k] & ~empty[k];
        assign valid[k] = count[k] != '0;
        noc_sync_fifo #(.WIDTH(WIDTH_PACKAGE), .DEPTH(DEPTH)) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (push[k]),
            .wdata(hold_data_q),
            .pop  (pop[k]),
            .rdata(rdata[k]),
            .full (full[k]),
            .empty(empty[k]),
            .count(count[k])
        );
    end

    // no bypass: a full target blocks the hold stage even if it pops this cycle
    always_comb begin
        dispatch     = hold_valid_q & ~full[hold_data_q[DEST_BIT]];
        in_ready     = rdy_q & (~hold_valid_q | dispatch);
        accept       = in_valid & in_ready;
        hold_valid_d = accept | (hold_valid_q & ~dispatch);
        hold_data_d  = accept ? in_data : hold_data_q;
        cnt0_d       = cnt0_q + CNT_W'(pop[OUT0]);
        cnt1_d       = cnt1_q + CNT_W'(pop[OUT1]);
    end

    assign out0_data  = rdata[OUT0];
    assign out1_data  = rdata[OUT1];
    assign out0_valid = valid[OUT0];
    assign out1_valid = valid[OUT1];
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            rdy_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            rdy_q        <= 1'b1;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end
endmodule

// File: tb/tb_noc_demux_2channel.sv
// tb_noc_demux_2channel: directed vector table plus hand-written sequences for
// backpressure, push/pop overlap, counter wrap and asynchronous reset.
module tb_noc_demux_2channel;
    localparam int W = 33;

    typedef struct {
        logic [W-1:0] din;
        logic         iv, r0, r1, ir, o0v, o1v;
        logic [W-1:0] o0d, o1d;
        logic [3:0]   c0, c1;
    } vec_t;

    logic         clk = 0, rst_n = 0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 0, in_ready;
    logic [W-1:0] out0_data, out1_data;
    logic         out0_valid, out1_valid;
    logic         out0_ready = 0, out1_ready = 0;
    logic [3:0]   cnt0, cnt1;

    int           n_chk = 0, n_fail = 0;
    logic [W-1:0] mq0[$], mq1[$], eq[$];
    vec_t         tbl[15];

    noc_demux_2channel #(.DEPTH(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // transfers are stable across the half cycle, so the falling edge sees what the rising edge takes
    always @(negedge clk)
        if (rst_n) begin
            if (out0_valid && out0_ready) mq0.push_back(out0_data);
            if (out1_valid && out1_ready) mq1.push_back(out1_data);
        end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] p);
        bit ok = 0;
        in_data  = p;
        in_valid = 1;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send timeout: in_ready got 0 expected 1 for %0h", p);
        end
    endtask

    task automatic chk_q(input string nm, input bit k);
        int n = k ? mq1.size() : mq0.size();
        chk({nm, " count"}, 64'(n), 64'(eq.size()));
        for (int i = 0; i < n && i < eq.size(); i++)
            chk($sformatf("%s pkt%0d", nm, i), k ? mq1[i] : mq0[i], eq[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 0;
        in_valid = 0;
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out0_valid", out0_valid, 0);
        chk("rst out1_valid", out1_valid, 0);
        chk("rst out0_data", out0_data, 0);
        chk("rst out1_data", out1_data, 0);
        chk("rst cnt0", cnt0, 0);
        chk("rst cnt1", cnt1, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
        #1;
        chk("rst release in_ready before edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("rst release in_ready after edge", in_ready, 1);
        mq0.delete();
        mq1.delete();
        eq.delete();
    endtask

    function automatic vec_t mk(logic [W-1:0] din, logic iv, logic r0, logic r1, logic ir,
                                logic o0v, logic [W-1:0] o0d, logic o1v, logic [W-1:0] o1d,
                                logic [3:0] c0, logic [3:0] c1);
        vec_t v;
        v.din = din; v.iv = iv; v.r0 = r0; v.r1 = r1; v.ir = ir;
        v.o0v = o0v; v.o0d = o0d; v.o1v = o1v; v.o1d = o1d; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(33'h1_0000_00AB, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 1, 1, 0, 0, 1, 33'h1_0000_00AB, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(33'h0_0000_0100, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(33'h1_0000_0101, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(33'h0_0000_0102, 1, 1, 1, 1, 1, 33'h0_0000_0100, 0, 0, 0, 1);
        tbl[7]  = mk(33'h1_0000_0103, 1, 1, 1, 1, 0, 0, 1, 33'h1_0000_0101, 1, 1);
        tbl[8]  = mk(33'h0_0000_0104, 1, 1, 1, 1, 1, 33'h0_0000_0102, 0, 0, 1, 2);
        tbl[9]  = mk(33'h1_0000_0105, 1, 1, 1, 1, 0, 0, 1, 33'h1_0000_0103, 2, 2);
        tbl[10] = mk(33'h0_0000_0106, 1, 1, 1, 1, 1, 33'h0_0000_0104, 0, 0, 2, 3);
        tbl[11] = mk(33'h1_0000_0107, 1, 1, 1, 1, 0, 0, 1, 33'h1_0000_0105, 3, 3);
        tbl[12] = mk(0, 0, 1, 1, 1, 1, 33'h0_0000_0106, 0, 0, 3, 4);
        tbl[13] = mk(0, 0, 1, 1, 1, 0, 0, 1, 33'h1_0000_0107, 4, 4);
        tbl[14] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 4, 5);

        repeat (2) @(posedge clk);
        do_reset();

        // single steer followed by an alternating back-to-back stream
        for (int i = 0; i < 15; i++) begin
            in_data    = tbl[i].din;
            in_valid   = tbl[i].iv;
            out0_ready = tbl[i].r0;
            out1_ready = tbl[i].r1;
            chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].ir);
            chk($sformatf("vec%0d out0_valid", i), out0_valid, tbl[i].o0v);
            chk($sformatf("vec%0d out1_valid", i), out1_valid, tbl[i].o1v);
            if (tbl[i].o0v) chk($sformatf("vec%0d out0_data", i), out0_data, tbl[i].o0d);
            if (tbl[i].o1v) chk($sformatf("vec%0d out1_data", i), out1_data, tbl[i].o1d);
            chk($sformatf("vec%0d cnt0", i), cnt0, tbl[i].c0);
            chk($sformatf("vec%0d cnt1", i), cnt1, tbl[i].c1);
            @(posedge clk);
            #1;
        end
        in_valid = 0;

        // backpressure on out0: two buffered, one held, input blocked
        do_reset();
        out0_ready = 0;
        out1_ready = 1;
        for (int i = 0; i < 3; i++) send(33'h0_0000_0A00 + 33'(i));
        chk("hol in_ready", in_ready, 0);
        chk("hol out0_valid", out0_valid, 1);
        chk("hol out0_data", out0_data, 33'h0_0000_0A00);
        idle(3);
        chk("hol still blocked", in_ready, 0);
        chk("hol cnt0", cnt0, 0);
        out0_ready = 1;
        send(33'h0_0000_0A03);
        idle(8);
        for (int i = 0; i < 4; i++) eq.push_back(33'h0_0000_0A00 + 33'(i));
        chk_q("hol out0 order", 0);
        chk("hol cnt0 drained", cnt0, 4);
        chk("hol out1 unused", 64'(mq1.size()), 0);

        // push and pop together on FIFO 1 at count 1, then a pop against a full FIFO
        do_reset();
        out0_ready = 1;
        out1_ready = 0;
        send(33'h1_0000_0B00);
        send(33'h1_0000_0B01);
        out1_ready = 1;
        idle(1);
        out1_ready = 0;
        chk("pp out1_valid", out1_valid, 1);
        chk("pp out1_data", out1_data, 33'h1_0000_0B01);
        chk("pp in_ready", in_ready, 1);
        send(33'h1_0000_0B02);
        send(33'h1_0000_0B03);
        chk("full in_ready", in_ready, 0);
        chk("full out1_data", out1_data, 33'h1_0000_0B01);
        chk("full cnt1", cnt1, 1);
        out1_ready = 1;
        idle(1);
        out1_ready = 0;
        chk("defer out1_data", out1_data, 33'h1_0000_0B02);
        chk("defer in_ready", in_ready, 1);
        chk("defer cnt1", cnt1, 2);
        idle(1);
        chk("defer pushed out1_valid", out1_valid, 1);
        chk("defer pushed out1_data", out1_data, 33'h1_0000_0B02);
        out1_ready = 1;
        idle(6);
        for (int i = 0; i < 4; i++) eq.push_back(33'h1_0000_0B00 + 33'(i));
        chk_q("pp out1 order", 1);
        chk("pp cnt1", cnt1, 4);

        // 17 deliveries wrap a 4-bit counter to 1
        do_reset();
        out0_ready = 1;
        out1_ready = 1;
        for (int i = 0; i < 17; i++) begin
            send(33'h0_0000_0C00 + 33'(i));
            eq.push_back(33'h0_0000_0C00 + 33'(i));
        end
        idle(5);
        chk_q("wrap out0", 0);
        chk("wrap cnt0", cnt0, 1);
        chk("wrap cnt1", cnt1, 0);

        // mid-operation reset discards everything held and buffered
        out0_ready = 0;
        send(33'h0_0000_0D00);
        send(33'h0_0000_0D01);
        idle(1);
        chk("pre-reset out0_valid", out0_valid, 1);
        do_reset();
        out0_ready = 1;
        idle(4);
        chk("post-reset out0_valid", out0_valid, 0);
        chk("post-reset nothing delivered", 64'(mq0.size()), 0);
        chk("post-reset cnt0", cnt0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_demux_2channel.md
Name: noc_demux_2channel

Overview:
- Splitter counterpart to the NoC 2-channel arbiter. It takes one merged packet stream and steers each packet to output 0 or output 1, selected by a destination bit in the packet.
- Sits on the receive side of a shared link, where the arbiter sits on the send side.
- Clocked valid/ready handshakes on all channels.
- Each output has its own FIFO, so a stalled output does not block the other until the input hold stage is occupied.

Parameters:
- WIDTH_PACKAGE, 33: packet width in bits.
- DEST_BIT, 32: index of the bit in the packet that selects the output (0 -> out0, 1 -> out1).
- DEPTH, 2: entries per output FIFO; power of 2, minimum 2.
- CNT_W, 16: width of the delivered-packet counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  WIDTH_PACKAGE  incoming packet.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out0_data  output  WIDTH_PACKAGE  head of FIFO 0.
- out0_valid  output  1  FIFO 0 not empty.
- out0_ready  input  1  sink 0 accepts.
- out1_data  output  WIDTH_PACKAGE  head of FIFO 1.
- out1_valid  output  1  FIFO 1 not empty.
- out1_ready  input  1  sink 1 accepts.
- cnt0  output  CNT_W  packets delivered on out0.
- cnt1  output  CNT_W  packets delivered on out1.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-low (rst_n). The polarity and synchronicity are fixed.
- While rst_n=0, or immediately on its falling edge:
  - hold stage empty, both FIFO pointers and counts 0, cnt0=cnt1=0;
  - out0_valid=out1_valid=0, in_ready=0, out*_data=0.
- in_ready returns to 1 on the first clk edge after rst_n deasserts.
- Reset mid-operation discards all packets held or buffered. No partial packet survives.
- Handshakes:
  - A transfer occurs on a rising edge when valid and ready are both 1.
  - valid never depends combinationally on ready.
  - A source must hold data stable while valid=1 and ready=0.
- Hold stage: one register (hold_data, hold_valid).
  - in_ready = ~hold_valid | dispatch.
  - dispatch = hold_valid & ~full[hold_data[DEST_BIT]].
  - On an input transfer, hold loads in_data. If hold is being dispatched in the same cycle, load and dispatch happen together, giving full throughput of 1 packet/cycle.
- Dispatch: the hold entry is pushed into the FIFO indexed by hold_data[DEST_BIT] in the cycle dispatch=1.
  - Push occurs only when that FIFO's count < DEPTH. A pop in the same cycle does not make room for the push; there is no bypass.
  - The hold stage keeps its entry while the target FIFO is full. This head-of-line blocking is intended: input order is preserved.
- FIFO: circular buffer with a count of 0..DEPTH.
  - outK_valid = (countK != 0); outK_data = storage[rd_ptr].
  - Simultaneous push and pop when not full or empty leaves count unchanged and advances both pointers.
  - Pointers wrap modulo DEPTH.
  - Pop with count 0 cannot occur, because valid=0.
- Latency:
  - packet accepted at edge N;
  - pushed at edge N+1 if space;
  - outK_valid=1 in the cycle after edge N+1.
  - Minimum latency is 2 cycles; throughput is 1 packet/cycle.
- Ordering: packets to the same output leave in input order. There is no ordering guarantee between out0 and out1.
- Counters:
  - cntK increments by 1 on each outK transfer, wrapping modulo 2^CNT_W with no saturation.
  - Both counters may increment in the same cycle.
- Full condition: with outK_ready=0, at most DEPTH packets wait in FIFO K plus 1 in hold. in_ready then falls to 0 once hold holds a packet for K.

Decomposition:
- Shared package noc_pkg holds:
  - the WIDTH_PACKAGE default (33) and the DEST_BIT position;
  - a typedef for the packet vector;
  - localparams for output IDs (OUT0=0, OUT1=1).
- Natural sub-module: noc_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice.
- The top level contains the hold stage, the dispatch logic and the counters.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle -> all valids, in_ready, cnt0 and cnt1 go to 0 at once, without waiting for a clk edge. in_ready=1 one edge after release.
- Single steer: send 0x1_0000_00AB (DEST_BIT=1), out1_ready=1 -> out1_valid=1 with data 0x1_0000_00AB exactly 2 cycles after acceptance. cnt1=1, cnt0=0, out0_valid never 1.
- Alternating stream: 8 back-to-back packets with dest 0,1,0,1..., both readies 1 -> in_ready stays 1, each output receives 4 packets in order, cnt0=cnt1=4.
- Backpressure/HOL: out0_ready=0, DEPTH=2, send 4 packets to dest 0 -> 2 buffered, 1 in hold, in_ready=0. Raising out0_ready drains all 4 in order.
- Simultaneous push/pop on FIFO 1 at count 1 -> count stays 1 and data order is preserved. Push to full FIFO 1 with a same-cycle pop -> push deferred one cycle, no loss or duplication.
- Counter wrap: CNT_W=4, deliver 17 packets on out0 -> cnt0 = 1.
